// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: RV32I instruction fetch stage.
// Issues sequential word-aligned fetches over a request/grant bus that answers
// in order with variable latency. Returned words and their PCs are buffered in
// a small FIFO, which is drained by the decoder under valid/ready. A redirect
// restarts fetch, flushes the FIFO and drops every response still in flight.
// Optional feature macro: IFETCH_BYPASS_EN. When defined, a kept response that
// finds the FIFO empty is presented to the decoder in the same cycle.

module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    // Fetch and response bookkeeping.
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard_cnt;

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic [AW:0]   occupancy;
    logic [OW-1:0] live;
    logic          empty;
    logic [31:0]   redirect_pc_aligned;
    logic          gnt;
    logic          rsp;
    logic          keep;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          unused_pc_bits;

    assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_bits      = ^redirect_pc_i[1:0];

    assign occupancy = wr_ptr - rd_ptr;
    assign live      = outstanding - discard_cnt;
    assign empty     = (wr_ptr == rd_ptr);

    // Credit rule: a request goes out only if every live response already has a
    // reserved FIFO slot, so a kept response can never find the FIFO full.
    assign imem_req_o  = !rst_i && !redirect_i
                       && (int'(outstanding) < MAX_OUTSTANDING)
                       && (int'(occupancy) + int'(live) < DEPTH);
    assign imem_addr_o = fetch_pc;

    // Handshake decode, optional bypass and decoder-facing outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        gnt     = imem_req_o && imem_gnt_i;
        // A response with nothing in flight is a bus error and is ignored.
        rsp     = imem_rvalid_i && (outstanding != '0);
        keep    = rsp && (discard_cnt == '0);
`ifdef IFETCH_BYPASS_EN
        bypass  = keep && empty && !redirect_i;
`else
        bypass  = 1'b0;
`endif
        pop     = !empty && instr_ready_i;
        // A bypassed word that the decoder takes at once never enters the FIFO.
        push    = keep && !(bypass && instr_ready_i);

        instr_valid_o = !rst_i && (!empty || bypass);
        instr_o       = '0;
        pc_o          = '0;
        if (!rst_i) begin
            if (!empty) begin
                instr_o = instr_mem[rd_ptr[AW-1:0]];
                pc_o    = pc_mem[rd_ptr[AW-1:0]];
            end else if (bypass) begin
                instr_o = imem_rdata_i;
                pc_o    = resp_pc;
            end
        end
    end

    // Control state: PCs, in-flight accounting and FIFO pointers.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_i) begin
            // Redirect overrides everything else this cycle; no grant can
            // happen because the request is withdrawn.
            fetch_pc    <= redirect_pc_aligned;
            resp_pc     <= redirect_pc_aligned;
            outstanding <= outstanding - OW'(rsp);
            discard_cnt <= outstanding - OW'(rsp);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (gnt) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            case ({gnt, rsp})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (rsp) begin
                if (discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - OW'(1);
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO payload write; entries are only read while the pointers say valid.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; the pointers alone define
        // which entries hold meaningful data.
        if (!rst_i && !redirect_i && push) begin
            instr_mem[wr_ptr[AW-1:0]] <= imem_rdata_i;
            pc_mem[wr_ptr[AW-1:0]]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue.
// A bus model answers grants in order after a per-request latency. The
// reference model is the architectural view: after reset or a redirect to P the
// decoder must see P, P+4, P+8, ... with the word stored at each address, and
// nothing from before the redirect. Directed phases check latencies, buffering
// limit and redirect behaviour; a randomized phase stresses everything else.

module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUT   = 2;
`ifdef IFETCH_BYPASS_EN
    localparam int          VLAT      = 2;
`else
    localparam int          VLAT      = 3;
`endif
    localparam int          TPUT_WIN  = 12;

    logic        clk;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    instr_fetch_queue #(
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    bus_req_t    mq[$];
    exp_t        sb[$];
    logic [31:0] model_pc = RESET_PC;

    int vectors    = 0;
    int miscompares = 0;

    int lat_min     = 1;
    int lat_max     = 1;
    bit lat_track   = 1'b0;
    bit lat_on      = 1'b0;
    int lat_ref     = 0;
    logic [31:0] lat_pc = '0;
    int gnt_win_cnt = 0;

    bit          prev_pend  = 1'b0;
    logic [31:0] prev_addr  = '0;
    bit          prev_redir = 1'b0;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle of stimulus, driven after the falling edge.
    task automatic drive(input bit rst, input bit redir, input logic [31:0] tgt,
                         input bit g, input bit rdy);
        @(negedge clk);
        rst_i         = rst;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        imem_gnt_i    = g;
        instr_ready_i = rdy && !redir;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    // Monitor: reference model update, scoreboard pops and timing checks.
    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            check("reset_outputs", {30'd0, imem_req_o, instr_valid_o, instr_o},
                  64'd0);
            check("reset_pc_out", {32'd0, pc_o}, 64'd0);
            sb.delete();
            mq.delete();
            model_pc   = RESET_PC;
            prev_pend  = 1'b0;
            prev_redir = 1'b0;
            if (lat_track) begin
                lat_on  = 1'b1;
                lat_ref = cyc;
                lat_pc  = RESET_PC;
            end
        end else begin
            if (prev_redir) begin
                check("empty_after_redirect", {63'd0, instr_valid_o}, 64'd0);
            end
            if (redirect_i) begin
                sb.delete();
                model_pc = {redirect_pc_i[31:2], 2'b00};
                check("req_in_redirect", {63'd0, imem_req_o}, 64'd0);
                if (lat_track) begin
                    lat_on  = 1'b1;
                    lat_ref = cyc;
                    lat_pc  = model_pc;
                end
            end else if (prev_pend) begin
                check("addr_stable", {31'd0, imem_req_o, imem_addr_o},
                      {31'd0, 1'b1, prev_addr});
            end

            if (imem_req_o && imem_gnt_i) begin
                exp_t     e;
                bus_req_t b;
                check("fetch_addr", {32'd0, imem_addr_o}, {32'd0, model_pc});
                e.instr = mem_word(model_pc);
                e.pc    = model_pc;
                sb.push_back(e);
                b.addr  = imem_addr_o;
                b.due   = cyc + int'($urandom_range(lat_min, lat_max));
                mq.push_back(b);
                model_pc = model_pc + 32'd4;
                gnt_win_cnt++;
            end

            if (!instr_valid_o) begin
                if ($urandom_range(0, 7) == 0) begin
                    check("idle_outputs_zero", {instr_o, pc_o}, 64'd0);
                end
            end else if (instr_ready_i) begin
                check("pop_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pc_order", {32'd0, pc_o}, {32'd0, e.pc});
                    check("instr_data", {32'd0, instr_o}, {32'd0, e.instr});
                end
            end

            if (lat_on && !redirect_i) begin
                int k;
                k = cyc - lat_ref;
                if (k >= 1 && k < VLAT) begin
                    check("valid_too_early", {63'd0, instr_valid_o}, 64'd0);
                end else if (k == VLAT) begin
                    check("first_valid", {31'd0, instr_valid_o, pc_o},
                          {31'd0, 1'b1, lat_pc});
                end else if (k > VLAT && k < VLAT + TPUT_WIN) begin
                    check("throughput", {63'd0, instr_valid_o}, 64'd1);
                end
                if (k >= VLAT + TPUT_WIN) lat_on = 1'b0;
            end

            prev_pend  = imem_req_o && !imem_gnt_i;
            prev_addr  = imem_addr_o;
            prev_redir = redirect_i;
        end
    end

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        instr_ready_i = 1'b0;

        // Reset, then streaming with 1-cycle memory: latency and throughput.
        lat_track = 1'b1;
        lat_min = 1; lat_max = 1;
        repeat (3) drive(1, 0, '0, 1, 1);
        repeat (20) drive(0, 0, '0, 1, 1);

        // Unaligned redirect target, then two back-to-back redirects.
        drive(0, 1, 32'h0000_0203, 1, 1);
        repeat (20) drive(0, 0, '0, 1, 1);
        drive(0, 1, 32'h0000_0040, 1, 1);
        drive(0, 1, 32'h0000_0080, 1, 1);
        repeat (20) drive(0, 0, '0, 1, 1);
        lat_track = 1'b0;

        // Grant withheld for three cycles; the address must hold.
        repeat (3) drive(0, 0, '0, 0, 1);
        repeat (4) drive(0, 0, '0, 1, 1);

        // Slow memory so two requests are in flight, then redirect.
        lat_min = 3; lat_max = 3;
        repeat (6) drive(0, 0, '0, 1, 1);
        drive(0, 1, 32'h0000_0100, 1, 1);
        repeat (15) drive(0, 0, '0, 1, 1);

        // Drain, then hold the decoder off: exactly DEPTH words get fetched.
        lat_min = 1; lat_max = 2;
        repeat (12) drive(0, 0, '0, 0, 1);
        gnt_win_cnt = 0;
        drive(0, 1, 32'h0000_0300, 1, 0);
        repeat (20) drive(0, 0, '0, 1, 0);
        #2;
        check("buffered_grants", 64'(gnt_win_cnt), 64'(DEPTH));
        check("full_stall", {62'd0, imem_req_o, instr_valid_o}, 64'b01);
        repeat (15) drive(0, 0, '0, 1, 1);

        // Randomized traffic with 1..5 cycle response latency.
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit rst, redir;
            r     = int'($urandom_range(0, 999));
            rst   = (r < 2);
            redir = !rst && (r < 30);
            drive(rst, redir, $urandom, ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 75));
        end

        // Final drain: nothing may be left undelivered.
        repeat (20) drive(0, 0, '0, 0, 1);
        #2;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("bus_drained", 64'(mq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage of the RV32I core. Generates sequential word-aligned fetch addresses, issues them to instruction memory over a request/grant bus with in-order, variable-latency responses, and buffers returned words with their PCs in a small FIFO. Its output feeds the decoder's `instr_i` under a valid/ready handshake. A branch/jump redirect restarts fetch at a new PC, flushes the queue and discards responses already in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered requests; at least 1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `redirect_i`  in  1  redirect request from execute; the PC is replaced this cycle.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address; always word-aligned.
- `imem_gnt_i`  in  1  request accepted when `imem_req_o && imem_gnt_i`.
- `imem_rvalid_i`  in  1  response valid; responses return in request order.
- `imem_rdata_i`  in  32  response instruction word.
- `instr_valid_o`  out  1  instruction available to the decoder.
- `instr_o`  out  32  instruction word.
- `pc_o`  out  32  PC of `instr_o`.
- `instr_ready_i`  in  1  the decoder consumes the entry when `instr_valid_o && instr_ready_i`.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next response to be kept.
  - `outstanding`: 0..MAX_OUTSTANDING, all requests in flight.
  - `discard_cnt`: in-flight responses to be dropped.
  - FIFO: DEPTH entries of {instr, pc}, with read/write pointers one bit wider than the index.
- `live = outstanding - discard_cnt`.
- Request condition:
  - `imem_req_o = !rst_i && !redirect_i && outstanding < MAX_OUTSTANDING && occupancy + live < DEPTH`.
  - With this credit rule, every kept response has a guaranteed slot, so the FIFO never overflows.
- `imem_addr_o = fetch_pc`.
- On grant: `fetch_pc += 4`, wrapping modulo 2^32; `outstanding` increments.
- On `imem_rvalid_i`, `outstanding` decrements. Grant and response in the same cycle leave it unchanged.
  - If `discard_cnt > 0`: the word is dropped and `discard_cnt` decrements.
  - Otherwise: push {`imem_rdata_i`, `resp_pc`}, then `resp_pc += 4`.
- `imem_rvalid_i` while `outstanding == 0` is a bus protocol error; it is ignored, with no state change.
- Pop: `instr_valid_o = !empty`. An entry is popped on handshake. Push and pop in the same cycle are allowed at any occupancy, including when the FIFO is full.
- Redirect has priority over every other event in its cycle:
  - `fetch_pc` and `resp_pc` take the aligned `redirect_pc_i`.
  - The FIFO empties, including any push or pop in that cycle.
  - `discard_cnt <= outstanding - (imem_rvalid_i ? 1 : 0)`.
  - `imem_req_o` is 0 in that cycle, so no grant is counted.
- Redirects on consecutive cycles: the last one wins, and `discard_cnt` is recomputed each time.
- When `instr_valid_o = 0`, `instr_o` and `pc_o` are driven to 0.

## Timing
- Reset values:
  - `imem_req_o=0`, `instr_valid_o=0`, `instr_o=0`, `pc_o=0`.
  - `fetch_pc=resp_pc=RESET_PC`, `outstanding=discard_cnt=0`, FIFO empty.
- First request is asserted in the first cycle after `rst_i` deasserts.
- Reset mid-operation abandons all in-flight responses. The bus is required to be reset together with this block.
- Load-to-use latency, without bypass:
  - Response in cycle N is pushed at the end of N.
  - `instr_valid_o` rises in N+1.
- Redirect in cycle R:
  - New-PC request is asserted in R+1.
  - If granted in R+1 with response in R+2, `instr_valid_o` rises in R+3.
- `imem_addr_o` holds stable while `imem_req_o=1` and no grant has occurred. A redirect may withdraw the request.
- Full throughput is one instruction per cycle with single-cycle-response memory and `MAX_OUTSTANDING >= 2`.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a kept response arrives, it is presented combinationally in the same cycle: `instr_valid_o=1`, `instr_o=imem_rdata_i`, `pc_o=resp_pc`.
  - If `instr_ready_i=1`, the word is consumed and not written to the FIFO. Otherwise it is pushed.
  - Load-to-use latency is 0 cycles; redirect-to-valid is R+2.
  - Bypass is suppressed in a redirect cycle.
- Not defined: all responses go through the FIFO, with the latencies given in Timing.

## Test plan
- Reset, memory with 1-cycle response and constant grant, `instr_ready_i=1` -> addresses 0x0, 0x4, 0x8… on consecutive cycles; `pc_o` and `instr_o` match in order; one instruction per cycle once the pipeline fills.
- `instr_ready_i=0` held, DEPTH=4 -> exactly 4 entries are buffered; `imem_req_o` drops once occupancy plus live reaches 4; no word is lost after ready returns.
- Redirect to 0x100 with 2 responses outstanding -> both late responses are dropped; next `pc_o` is 0x100; the FIFO is empty in R+1.
- Redirect to 0x203 -> fetch at 0x200; redirect on two consecutive cycles (0x40, then 0x80) -> first valid `pc_o` is 0x80.
- `imem_gnt_i` withheld for 3 cycles -> `imem_addr_o` stays stable; random response latency of 1-5 cycles gives in-order PCs with no duplicates.
- With `IFETCH_BYPASS_EN`, empty FIFO, response in cycle N and ready=1 -> `instr_valid_o=1` in N; without the macro, `instr_valid_o=1` in N+1.
